display_scan: RTL and testbench
===============================

Name: display_scan

Overview:
- Downstream consumer of the 10 kHz display strobe `clk_display`, which is produced on the 27 MHz system clock.
- Time-multiplexes a 4-digit BCD value onto a shared 7-segment bus and per-digit anode enables.
- Samples the strobe inside the `clk` domain, so the block is single-clock.
- Provides tear-free updates: new data is adopted only at a frame boundary.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; the digit index is 2 bits for the default.
- SEG_ACTIVE_LOW, 1, when 1 a lit segment is driven 0 (common-anode panel).
- AN_ACTIVE_LOW, 1, when 1 a selected anode is driven 0.

Ports:
- clk  in  1  system clock, 27 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- clk_display  in  1  10 kHz square-wave strobe; treated as data, never used as a clock.
- data_in  in  4*NUM_DIGITS  BCD value; nibble 0 is the least significant digit.
- data_valid  in  1  one-cycle write strobe for data_in.
- blank_lz  in  1  1 = blank leading zeros.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- an  out  NUM_DIGITS  digit enables, polarity per AN_ACTIVE_LOW; at most one active.
- frame_done  out  1  one-cycle pulse when the digit index wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Digit index = 0; shown and pending registers = 0; pending flag = 0; sync flops = 0.
  - seg = all segments off (7'h7F when SEG_ACTIVE_LOW); an = all inactive (4'hF when AN_ACTIVE_LOW); frame_done = 0.
  - The first scan after release starts at digit 0.
- Strobe detection:
  - 2-flop synchroniser, then a previous-value flop.
  - tick = sync2 & ~prev, one `clk` cycle per rising edge of clk_display.
  - Latency from the clk_display rising edge to tick is 2–3 clk cycles.
  - Tick period is 2700 clk cycles at nominal strobe.
- Scan counter:
  - On tick, the index advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - A full frame is 4 ticks (400 µs).
  - seg and an are registered and reflect the new index in the cycle after tick.
- Write handshake:
  - On data_valid, data_in is captured into the pending register and the pending flag is set.
  - The last write before a frame boundary wins. There is no back-pressure; the block is always ready.
- Frame boundary (tick with index == NUM_DIGITS-1):
  - If the pending flag is set, shown <= pending and the flag is cleared.
  - frame_done pulses in the same cycle in which the index becomes 0.
  - If data_valid coincides with the boundary tick, the new data_in goes directly to shown and the flag stays clear.
- Decode:
  - Nibbles 0–9 use standard 7-segment glyphs.
  - Nibbles 10–15 show a dash (segment g only).
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked (seg all off, anode still driven for the time slot) if k > 0 and every digit from k up to NUM_DIGITS-1 is 0.
  - Digit 0 is never blanked, so 0000 displays "0".
  - blank_lz is sampled combinationally against shown; a change takes effect on the next registered update.
- Strobe stopped: the index holds and the current digit stays lit; no timeout.
- Reset mid-frame: outputs go to their reset values immediately; pending data is discarded.

Decomposition:
- Shared package `display_pkg`:
  - Segment glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - Typedef `bcd_digit_t` (logic [3:0]).
  - Default NUM_DIGITS.
- Sub-module `bcd_to_7seg`: combinational nibble → active-high 7-bit glyph.
- Polarity inversion and the blanking mux stay in display_scan.

Test Plan:
- Reset, then data_valid with data_in=16'h1234, strobe running:
  - After the first frame boundary, the an sequence is 4'hE, 4'hD, 4'hB, 4'h7.
  - Corresponding seg = glyphs 4, 3, 2, 1 (7'h19, 7'h30, 7'h24, 7'h79 active-low).
- Tick cadence: count clk cycles between an changes → 2700 ±1; frame_done period = 10800.
- Tearing: write 16'h5678 while index=1 → digits 2 and 3 keep the old value until the wrap, then 5678 appears from digit 0.
  - Write 16'h1111 then 16'h2222 within one frame → only 2222 is shown.
- Blanking: data_in=16'h0070, blank_lz=1 → digits 3 and 2 have seg=7'h7F; digit 1 shows "7", digit 0 shows "0".
  - data_in=16'h0000 → only digit 0 lit, showing "0".
  - blank_lz=0 → all four digits show "0".
- Invalid BCD: data_in=16'hA9F0 → digits 3 and 1 show a dash (7'h3F active-low); digit 2 shows "9".
- Reset asserted mid-frame at index=2 → same cycle an=4'hF, seg=7'h7F, frame_done=0.
  - After release, the next tick selects digit 1 (index 0→1). Digit 0 is active-low-selected only after the 4th tick, and it shows "0" because pending was cleared.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and 7-segment glyph constants for the display scan block.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int unsigned DEFAULT_NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment glyph.
// Non-decimal codes render as a dash so corrupt data is visible on the panel.
module bcd_to_7seg
    import display_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  glyph
);

    always_comb begin
        glyph = SEG_DASH;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner driven by a strobe sampled in the clk domain.
// New data is held pending and adopted only at a frame boundary to avoid tearing.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = DEFAULT_NUM_DIGITS,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_display,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic                      data_valid,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic sync1_q, sync2_q, prev_q;
    logic tick, wrap;

    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shown_q, shown_d;
    logic [4*NUM_DIGITS-1:0]   pend_q, pend_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [6:0]                seg_q;
    logic [NUM_DIGITS-1:0]     an_q;
    logic                      frame_done_q;

    bcd_digit_t                digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     blank_vec;
    logic                      all_zero;
    bcd_digit_t                cur_digit;
    logic [6:0]                glyph;
    logic [6:0]                seg_lit;
    logic [6:0]                seg_next;
    logic [NUM_DIGITS-1:0]     an_sel;
    logic [NUM_DIGITS-1:0]     an_next;

    assign tick = sync2_q & ~prev_q;
    assign wrap = tick && (idx_q == LAST_IDX);

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // A write landing on the boundary tick bypasses pending and goes straight to shown.
    always_comb begin
        shown_d    = shown_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (wrap) begin
            pend_vld_d = 1'b0;
            if (data_valid) begin
                shown_d = data_in;
                pend_d  = data_in;
            end else if (pend_vld_q) begin
                shown_d = pend_q;
            end
        end else if (data_valid) begin
            pend_d     = data_in;
            pend_vld_d = 1'b1;
        end
    end

    // Outputs are built from next-state so they show the new slot right after the tick.
    always_comb begin
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digits[k]    = shown_d[4*k +: 4];
            all_zero     = all_zero & (digits[k] == 4'd0);
            blank_vec[k] = blank_lz && all_zero && (k > 0);
        end
    end

    assign cur_digit = digits[idx_d];

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .glyph (glyph)
    );

    always_comb begin
        seg_lit  = blank_vec[idx_d] ? SEG_OFF : glyph;
        seg_next = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        an_sel        = '0;
        an_sel[idx_d] = 1'b1;
        an_next  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            idx_q        <= '0;
            shown_q      <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_IDLE;
            an_q         <= AN_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            sync1_q      <= clk_display;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            frame_done_q <= wrap;
            if (tick) begin
                seg_q <= seg_next;
                an_q  <= an_next;
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: scan order, cadence, tear-free updates,
// blanking, invalid BCD and mid-frame reset, with hand-computed glyphs.
module tb_display_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_display = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_vec  = 0;
    int n_miss = 0;
    int half_per = 1350;
    bit strobe_en = 1'b0;

    display_scan dut (
        .clk         (clk),
        .reset       (reset),
        .clk_display (clk_display),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Strobe source: half-period counted in clk cycles, toggled away from the active edge.
    initial begin
        forever begin
            repeat (half_per) @(negedge clk);
            if (strobe_en) clk_display = ~clk_display;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [3:0] exp_an,
                              input logic [6:0] exp_seg);
        check_eq({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
        check_eq({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
    endtask

    task automatic write_data(input logic [15:0] d);
        @(negedge clk);
        data_in    = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_slot(output int n);
        logic [3:0] prev;
        prev = an;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an === prev && n < 3000);
        check_eq("slot_timeout", {31'd0, an === prev}, 32'd0);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 15000);
        check_eq("frame_timeout", {31'd0, frame_done !== 1'b1}, 32'd0);
    endtask

    initial begin
        int n;
        int acc;

        repeat (3) @(negedge clk);
        check_eq("rst_an", {28'd0, an}, 32'hF);
        check_eq("rst_seg", {25'd0, seg}, 32'h7F);
        check_eq("rst_fd", {31'd0, frame_done}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        write_data(16'h1234);
        strobe_en = 1'b1;

        // Nominal strobe: scan order and cadence
        wait_frame(n);
        check_slot("f1_d0", 4'hE, 7'h19);
        acc = 0;
        wait_slot(n);
        acc += n;
        check_eq("tick_period", n, 32'd2700);
        check_slot("f1_d1", 4'hD, 7'h30);
        wait_slot(n);
        acc += n;
        check_slot("f1_d2", 4'hB, 7'h24);
        wait_slot(n);
        acc += n;
        check_slot("f1_d3", 4'h7, 7'h79);
        wait_frame(n);
        acc += n;
        check_eq("frame_period", acc, 32'd10800);
        check_slot("f2_d0", 4'hE, 7'h19);

        // Fast strobe for the remaining scenarios
        half_per = 10;

        // Write during index 1: digits 2/3 keep old data until the wrap
        wait_frame(n);
        wait_slot(n);
        check_slot("tear_d1", 4'hD, 7'h30);
        write_data(16'h5678);
        wait_slot(n);
        check_slot("tear_d2", 4'hB, 7'h24);
        wait_slot(n);
        check_slot("tear_d3", 4'h7, 7'h79);
        wait_frame(n);
        check_slot("tear_new_d0", 4'hE, 7'h00);
        wait_slot(n);
        check_slot("tear_new_d1", 4'hD, 7'h78);

        // Two writes in one frame: the last one wins
        wait_frame(n);
        write_data(16'h1111);
        write_data(16'h2222);
        wait_frame(n);
        check_slot("last_d0", 4'hE, 7'h24);
        wait_slot(n);
        check_slot("last_d1", 4'hD, 7'h24);

        // Leading-zero blanking
        blank_lz = 1'b1;
        write_data(16'h0070);
        wait_frame(n);
        check_slot("lz70_d0", 4'hE, 7'h40);
        wait_slot(n);
        check_slot("lz70_d1", 4'hD, 7'h78);
        wait_slot(n);
        check_slot("lz70_d2", 4'hB, 7'h7F);
        wait_slot(n);
        check_slot("lz70_d3", 4'h7, 7'h7F);

        write_data(16'h0000);
        wait_frame(n);
        check_slot("lz00_d0", 4'hE, 7'h40);
        wait_slot(n);
        check_slot("lz00_d1", 4'hD, 7'h7F);
        wait_slot(n);
        check_slot("lz00_d2", 4'hB, 7'h7F);
        wait_slot(n);
        check_slot("lz00_d3", 4'h7, 7'h7F);

        wait_frame(n);
        check_slot("nolz_d0", 4'hE, 7'h40);
        blank_lz = 1'b0;
        wait_slot(n);
        check_slot("nolz_d1", 4'hD, 7'h40);
        wait_slot(n);
        check_slot("nolz_d2", 4'hB, 7'h40);
        wait_slot(n);
        check_slot("nolz_d3", 4'h7, 7'h40);

        // Invalid BCD shows a dash
        write_data(16'hA9F0);
        wait_frame(n);
        check_slot("inv_d0", 4'hE, 7'h40);
        wait_slot(n);
        check_slot("inv_d1", 4'hD, 7'h3F);
        wait_slot(n);
        check_slot("inv_d2", 4'hB, 7'h10);
        wait_slot(n);
        check_slot("inv_d3", 4'h7, 7'h3F);

        // Reset at index 2 with pending data outstanding
        wait_frame(n);
        write_data(16'h9999);
        wait_slot(n);
        wait_slot(n);
        check_slot("pre_rst_d2", 4'hB, 7'h10);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_an", {28'd0, an}, 32'hF);
        check_eq("mid_rst_seg", {25'd0, seg}, 32'h7F);
        check_eq("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_slot(n);
        check_slot("post_rst_t1", 4'hD, 7'h40);
        wait_slot(n);
        check_slot("post_rst_t2", 4'hB, 7'h40);
        wait_slot(n);
        check_slot("post_rst_t3", 4'h7, 7'h40);
        wait_frame(n);
        check_slot("post_rst_t4", 4'hE, 7'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
